// File: rtl/system_param_bank_if.sv
// Avalon-MM slave bus bundle for the parameter bank: word address, select,
// active-low write strobe, write data and zero-wait-state read data.
interface system_param_bank_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/system_param_bank.sv
// Shadowed parameter bank: software fills shadow words, the set is copied to out_port
// atomically when armed and seq_idle. PARAM_BANK_ACTIVE_READBACK_EN adds active readback.
module system_param_bank #(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int RESET_VAL = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  system_param_bank_if.slave       bus,
  input  logic                     seq_idle,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     commit_done
);

  localparam int                IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] CNT_A  = ADDR_W'(NUM_CH + 1);
  localparam logic [DATA_W-1:0] RST_W  = DATA_W'(RESET_VAL);

  typedef enum logic {ST_IDLE, ST_ARMED} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] active_q [NUM_CH];
  logic [15:0]       count_q;
  logic              wr_en, shadow_we, ctrl_we, transfer;
  logic [IDX_W-1:0]  wr_idx;
  logic              unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign shadow_we    = wr_en && (bus.address < CTRL_A);
  assign ctrl_we      = wr_en && (bus.address == CTRL_A);
  assign wr_idx       = bus.address[IDX_W-1:0];
  assign unused_wdata = ^bus.writedata;

  // A transfer uses the registered state only, so an abort landing on the
  // transfer cycle is too late to stop it.
  always_comb begin
    state_d  = state_q;
    transfer = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_we && bus.writedata[0] && !bus.writedata[1]) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (seq_idle) begin
          transfer = 1'b1;
          state_d  = ST_IDLE;
        end else if (ctrl_we && bus.writedata[1]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      commit_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      commit_done <= transfer;
      if (transfer) count_q <= count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= RST_W;
        active_q[i] <= RST_W;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // active takes the pre-edge shadow, so a same-cycle shadow write waits for the next commit
        if (transfer) active_q[i] <= shadow_q[i];
        if (shadow_we && (wr_idx == IDX_W'(i))) shadow_q[i] <= bus.writedata[DATA_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = active_q[g];
  end

`ifdef PARAM_BANK_ACTIVE_READBACK_EN
  localparam logic [ADDR_W-1:0] RB_LO = ADDR_W'(NUM_CH + 2);
  localparam logic [ADDR_W-1:0] RB_HI = ADDR_W'(2 * NUM_CH + 1);
  logic [ADDR_W-1:0] rb_off;
  assign rb_off = bus.address - RB_LO;
`endif

  always_comb begin
    bus.readdata = '0;
    if (bus.address < CTRL_A) begin
      bus.readdata = 32'(shadow_q[wr_idx]);
    end else if (bus.address == CTRL_A) begin
      bus.readdata = {30'd0, seq_idle, (state_q == ST_ARMED)};
    end else if (bus.address == CNT_A) begin
      bus.readdata = {16'd0, count_q};
`ifdef PARAM_BANK_ACTIVE_READBACK_EN
    end else if ((bus.address >= RB_LO) && (bus.address <= RB_HI)) begin
      bus.readdata = 32'(active_q[rb_off[IDX_W-1:0]]);
`endif
    end
  end

endmodule

// File: tb/tb_system_param_bank.sv
// Directed bench for system_param_bank: expected values queued at stimulus time,
// popped and compared when the DUT output is sampled.
module tb_system_param_bank;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] A_CTRL = 5'd8;
  localparam logic [ADDR_W-1:0] A_CNT  = 5'd9;
  localparam logic [ADDR_W-1:0] A_RB5  = 5'd15;
  localparam logic [ADDR_W-1:0] A_TOP  = 5'd31;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     seq_idle = 1'b0;
  logic [NUM_CH*DATA_W-1:0] out_port;
  logic                     commit_done;

  system_param_bank_if #(.ADDR_W(ADDR_W)) bus ();

  system_param_bank #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_VAL(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .seq_idle(seq_idle),
    .out_port(out_port), .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rd;
  int          lat;

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  function automatic logic [31:0] ch(input int i);
    return out_port[i*DATA_W +: DATA_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      expect_v(32'd16);
      check($sformatf("rst_ch%0d", i), ch(i));
    end
    expect_v(32'd0); bus_read(A_CTRL, rd); check("rst_ctrl", rd);
    expect_v(32'd0); bus_read(A_CNT, rd);  check("rst_count", rd);
    expect_v(32'd0); check("rst_commit_done", {31'd0, commit_done});

    // armed but sequencer busy: nothing moves
    bus_write(5'd3, 32'h1234);
    bus_write(A_CTRL, 32'h1);
    repeat (10) tick();
    expect_v(32'd16);     check("busy_ch3", ch(3));
    expect_v(32'h1);      bus_read(A_CTRL, rd); check("busy_pending", rd);
    expect_v(32'h1234);   bus_read(5'd3, rd);   check("shadow3_rd", rd);

    seq_idle = 1'b1;
    lat = 0;
    for (int k = 1; k <= 5 && lat == 0; k++) begin
      tick();
      if (commit_done) lat = k;
    end
    expect_v(32'd1);      check("commit_latency", lat);
    expect_v(32'h1234);   check("commit_ch3", ch(3));
    expect_v(32'd1);      bus_read(A_CNT, rd); check("count_1", rd);
    tick();
    expect_v(32'd0);      check("commit_done_single", {31'd0, commit_done});
    expect_v(32'h2);      bus_read(A_CTRL, rd); check("ctrl_idle_hi", rd);

    // abort wins over arm
    seq_idle = 1'b0;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_CTRL, 32'h3);
    expect_v(32'h0);      bus_read(A_CTRL, rd); check("abort_pending", rd);
    seq_idle = 1'b1;
    repeat (3) tick();
    expect_v(32'd1);      bus_read(A_CNT, rd); check("abort_count", rd);
    expect_v(32'd0);      check("abort_no_pulse", {31'd0, commit_done});

    // shadow write on the transfer cycle
    seq_idle = 1'b0;
    bus_write(5'd0, 32'h5555);
    bus_write(A_CTRL, 32'h1);
    seq_idle = 1'b1;
    bus_write(5'd0, 32'hAAAA);
    expect_v(32'h5555);   check("coll_active0", ch(0));
    expect_v(32'd1);      check("coll_pulse", {31'd0, commit_done});
    expect_v(32'hAAAA);   bus_read(5'd0, rd); check("coll_shadow0", rd);
    expect_v(32'd2);      bus_read(A_CNT, rd); check("count_2", rd);
    bus_write(A_CTRL, 32'h1);
    tick();
    expect_v(32'hAAAA);   check("b2b_active0", ch(0));
    expect_v(32'd3);      bus_read(A_CNT, rd); check("count_3", rd);

    // abort on the transfer cycle is ignored
    seq_idle = 1'b0;
    bus_write(5'd1, 32'h77);
    bus_write(A_CTRL, 32'h1);
    seq_idle = 1'b1;
    bus_write(A_CTRL, 32'h2);
    expect_v(32'h77);     check("late_abort_ch1", ch(1));
    expect_v(32'd4);      bus_read(A_CNT, rd); check("count_4", rd);

    // read-only and unmapped addresses
    bus_write(A_CNT, 32'h55);
    bus_write(A_TOP, 32'hFFFF_FFFF);
    expect_v(32'd4);      bus_read(A_CNT, rd); check("count_ro", rd);
    expect_v(32'd0);      bus_read(A_TOP, rd); check("top_addr_zero", rd);

    // counter wrap, preloaded near the top
    seq_idle = 1'b0;
    force dut.count_q = 16'hFFFE;
    tick();
    release dut.count_q;
    expect_v(32'hFFFE);   bus_read(A_CNT, rd); check("count_preload", rd);
    seq_idle = 1'b1;
    bus_write(A_CTRL, 32'h1);
    tick();
    expect_v(32'hFFFF);   bus_read(A_CNT, rd); check("count_ffff", rd);
    bus_write(A_CTRL, 32'h1);
    tick();
    expect_v(32'h0);      bus_read(A_CNT, rd); check("count_wrap", rd);

    // reset while armed discards the commit
    seq_idle = 1'b0;
    bus_write(5'd2, 32'h99);
    bus_write(A_CTRL, 32'h1);
    reset = 1'b1;
    #2;
    expect_v(32'd16);     check("async_rst_ch1", ch(1));
    tick();
    tick();
    reset = 1'b0;
    seq_idle = 1'b1;
    repeat (3) tick();
    expect_v(32'd16);     check("post_rst_ch2", ch(2));
    expect_v(32'd0);      bus_read(A_CNT, rd); check("post_rst_count", rd);
    expect_v(32'd0);      check("post_rst_pulse", {31'd0, commit_done});
    expect_v(32'h2);      bus_read(A_CTRL, rd); check("post_rst_ctrl", rd);
    expect_v(32'd16);     bus_read(5'd2, rd); check("post_rst_shadow2", rd);

    // active readback window
    bus_write(5'd5, 32'hBEEF);
    bus_write(A_CTRL, 32'h1);
    tick();
    expect_v(32'hBEEF);   check("rb_ch5", ch(5));
`ifdef PARAM_BANK_ACTIVE_READBACK_EN
    expect_v(32'hBEEF);
`else
    expect_v(32'h0);
`endif
    bus_read(A_RB5, rd);  check("rb_addr", rd);
    expect_v(32'h0);      bus_read(A_TOP, rd); check("rb_top_zero", rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
